hc_sr04_emulator: RTL

Responder-side model of the HC-SR04 ultrasonic ranging sensor, for synthesis into a second FPGA or use as a bench target. It accepts the trigger pulse produced by an `hc_sr04` initiator and returns an echo pulse whose width, in clock cycles, equals a programmed range value. This lets radar designs be exercised without a physical sensor. Echo width uses the same units as the `hc_sr04` `range` output (one count = one clock period; 20 ns at 50 MHz), so a measured range reads back equal to the programmed value.

---
 rtl/hc_sr04_emulator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hc_sr04_emulator.sv
// HC-SR04 responder: qualifies a trigger pulse, then returns an echo whose width equals the latched range.
// Latency: echo rises BURST_CYCLES+3 edges after trigger is first sampled low; no backpressure.
// Optional `burst` 40 kHz tone output during BURST when HC_SR04_EMU_BURST_OUT_EN is defined.
module hc_sr04_emulator #(
  parameter int unsigned TRIG_MIN_CYCLES = 500,
  parameter int unsigned BURST_CYCLES    = 10000,
  parameter int unsigned ECHO_MAX_CYCLES = 1900000,
  parameter int unsigned HOLDOFF_CYCLES  = 500000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [31:0] range_cycles,
  output logic        echo,
  output logic        busy,
  output logic        short_trig
`ifdef HC_SR04_EMU_BURST_OUT_EN
  ,
  output logic        burst
`endif
);

  localparam logic [31:0] TRIG_MIN = 32'(TRIG_MIN_CYCLES);
  localparam logic [31:0] BURST_N  = 32'(BURST_CYCLES);
  localparam logic [31:0] ECHO_MAX = 32'(ECHO_MAX_CYCLES);
  localparam logic [31:0] HOLD_N   = 32'(HOLDOFF_CYCLES);

  typedef enum logic [2:0] {IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF} state_t;

  state_t      state;
  logic        trig_meta;
  logic        trig_s;
  logic        trig_d;
  logic [31:0] trig_cnt;
  logic [31:0] phase_cnt;
  logic [31:0] width_q;
  logic        trig_rise;
  logic        trig_fall;

  assign trig_rise = trig_s & ~trig_d;
  assign trig_fall = ~trig_s & trig_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
      trig_d    <= 1'b0;
    end else begin
      trig_meta <= trigger;
      trig_s    <= trig_meta;
      trig_d    <= trig_s;
    end
  end

  // echo is a registered copy of state==ECHO, which gives the extra edge of latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      trig_cnt   <= 32'd0;
      phase_cnt  <= 32'd0;
      width_q    <= 32'd0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      short_trig <= 1'b0;
    end else begin
      short_trig <= 1'b0;
      echo       <= (state == ECHO);
      case (state)
        IDLE: begin
          if (trig_rise) begin
            state    <= TRIG_HIGH;
            trig_cnt <= 32'd1;
            busy     <= 1'b1;
          end
        end
        TRIG_HIGH: begin
          if (trig_fall) begin
            if (trig_cnt >= TRIG_MIN) begin
              width_q   <= (range_cycles == 32'd0 || range_cycles > ECHO_MAX) ? ECHO_MAX : range_cycles;
              phase_cnt <= 32'd1;
              state     <= BURST;
            end else begin
              short_trig <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else if (trig_s && trig_cnt != TRIG_MIN) begin
            trig_cnt <= trig_cnt + 32'd1;
          end
        end
        BURST: begin
          if (phase_cnt == BURST_N) begin
            phase_cnt <= 32'd1;
            state     <= ECHO;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        ECHO: begin
          if (phase_cnt == width_q) begin
            phase_cnt <= 32'd1;
            state     <= HOLDOFF;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        HOLDOFF: begin
          if (phase_cnt == HOLD_N) begin
            phase_cnt <= 32'd0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef HC_SR04_EMU_BURST_OUT_EN
  localparam logic [9:0] TONE_HALF = 10'd624;

  logic [9:0] tone_cnt;
  logic       tone;

  // tone restarts high on every BURST entry; burst lags state by one edge like echo
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tone_cnt <= 10'd0;
      tone     <= 1'b1;
      burst    <= 1'b0;
    end else if (state != BURST) begin
      tone_cnt <= 10'd0;
      tone     <= 1'b1;
      burst    <= 1'b0;
    end else begin
      burst <= tone;
      if (tone_cnt == TONE_HALF) begin
        tone_cnt <= 10'd0;
        tone     <= ~tone;
      end else begin
        tone_cnt <= tone_cnt + 10'd1;
      end
    end
  end
`endif

endmodule
